// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, response and memory-side signals for dmem_arbiter.
// The arbiter connects through the slave modport; the requesters and the
// memory model sit on the master side.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // Debug exclusive mode
  logic                  i_dbg_lock;

  // CPU (requester 0)
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [ADDR_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_ack;
  logic [DATA_WIDTH-1:0] o_cpu_rdata;
  logic                  o_cpu_err;
  logic                  o_cpu_stall;

  // Debug unit (requester 1)
  logic                  i_dbg_req;
  logic                  i_dbg_we;
  logic [ADDR_WIDTH-1:0] i_dbg_addr;
  logic [DATA_WIDTH-1:0] i_dbg_wdata;
  logic                  o_dbg_ack;
  logic [DATA_WIDTH-1:0] o_dbg_rdata;
  logic                  o_dbg_err;

  // Single-port data memory
  logic                  o_mem_valid;
  logic                  o_mem_read_enable;
  logic                  o_mem_write_enable;
  logic [ADDR_WIDTH-1:0] o_mem_address;
  logic [DATA_WIDTH-1:0] o_mem_write_data;
  logic [DATA_WIDTH-1:0] i_mem_read_data;

  // Statistics
  logic [CNT_WIDTH-1:0]  o_conflict_count;

  modport slave (
    input  i_dbg_lock,
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_ack, o_cpu_rdata, o_cpu_err, o_cpu_stall,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    output o_dbg_ack, o_dbg_rdata, o_dbg_err,
    output o_mem_valid, o_mem_read_enable, o_mem_write_enable,
    output o_mem_address, o_mem_write_data,
    input  i_mem_read_data,
    output o_conflict_count
  );

  modport master (
    output i_dbg_lock,
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_ack, o_cpu_rdata, o_cpu_err, o_cpu_stall,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
    input  o_dbg_ack, o_dbg_rdata, o_dbg_err,
    input  o_mem_valid, o_mem_read_enable, o_mem_write_enable,
    input  o_mem_address, o_mem_write_data,
    output i_mem_read_data,
    input  o_conflict_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// MEM stage (requester 0) and the debug unit (requester 1). One memory cycle
// per grant, followed by a registered one-cycle acknowledge with read data.
// The debug lock removes the CPU from arbitration while the CPU is halted.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  dmem_arbiter_if.slave        bus
);

  localparam int NREQ    = 2;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  // One extra bit so MEM_DEPTH itself is representable in the compare.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic {
    LAST_CPU = 1'b0,
    LAST_DBG = 1'b1
  } last_e;

  last_e last_q, last_d;

  // Per-requester views of the request side, indexed by requester number.
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [ADDR_WIDTH-1:0] addr  [NREQ];
  logic [DATA_WIDTH-1:0] wdata [NREQ];
  logic [NREQ-1:0]       ack_q;
  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       grant;

  // Winner's fields, muxed for the memory port.
  logic                  any_grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign req[REQ_CPU]   = bus.i_cpu_req;
  assign we[REQ_CPU]    = bus.i_cpu_we;
  assign addr[REQ_CPU]  = bus.i_cpu_addr;
  assign wdata[REQ_CPU] = bus.i_cpu_wdata;
  assign req[REQ_DBG]   = bus.i_dbg_req;
  assign we[REQ_DBG]    = bus.i_dbg_we;
  assign addr[REQ_DBG]  = bus.i_dbg_addr;
  assign wdata[REQ_DBG] = bus.i_dbg_wdata;

  // A requester whose ack is showing is never re-serviced that cycle, so it
  // can update its fields without being issued twice.
  assign elig[REQ_CPU] = req[REQ_CPU] & ~ack_q[REQ_CPU] & ~bus.i_dbg_lock;
  assign elig[REQ_DBG] = req[REQ_DBG] & ~ack_q[REQ_DBG];

  // Last-grant register: decides the tie-break for the next contended cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_q <= LAST_DBG;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant selection and last-grant update.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    if (elig[REQ_CPU] && elig[REQ_DBG]) begin
      if (last_q == LAST_DBG) begin
        grant[REQ_CPU] = 1'b1;
      end else begin
        grant[REQ_DBG] = 1'b1;
      end
    end else begin
      grant = elig;
    end
    if (grant[REQ_CPU]) begin
      last_d = LAST_CPU;
    end else if (grant[REQ_DBG]) begin
      last_d = LAST_DBG;
    end
  end

  // Route the winner's request to the memory port.
  always_comb begin
    any_grant = |grant;
    sel_we    = grant[REQ_DBG] ? we[REQ_DBG]    : we[REQ_CPU];
    sel_addr  = grant[REQ_DBG] ? addr[REQ_DBG]  : addr[REQ_CPU];
    sel_wdata = grant[REQ_DBG] ? wdata[REQ_DBG] : wdata[REQ_CPU];
    in_range  = ({1'b0, sel_addr} < DEPTH_X);
  end

  // Memory strobes stay low with no grant or an out-of-range address, so a
  // rejected access never disturbs memory contents.
  always_comb begin
    bus.o_mem_valid        = 1'b0;
    bus.o_mem_read_enable  = 1'b0;
    bus.o_mem_write_enable = 1'b0;
    bus.o_mem_address      = '0;
    bus.o_mem_write_data   = '0;
    if (any_grant && in_range) begin
      bus.o_mem_valid        = 1'b1;
      bus.o_mem_read_enable  = ~sel_we;
      bus.o_mem_write_enable = sel_we;
      bus.o_mem_address      = sel_addr;
      bus.o_mem_write_data   = sel_wdata;
    end
  end

  // Per-requester registered response: ack, error flag and read data.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : gen_resp
      logic                  ack_r_q, ack_r_d;
      logic                  err_q, err_d;
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      // Next response: only the winner acks; everyone else returns to zero.
      always_comb begin
        ack_r_d = grant[gi];
        err_d   = grant[gi] & ~in_range;
        rdata_d = '0;
        if (grant[gi] && in_range && !sel_we) begin
          rdata_d = bus.i_mem_read_data;
        end
      end

      // Response registers; reset drops any pending ack.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          ack_r_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          ack_r_q <= ack_r_d;
          err_q   <= err_d;
          rdata_q <= rdata_d;
        end
      end

      assign ack_q[gi] = ack_r_q;
    end
  endgenerate

  assign bus.o_cpu_ack   = gen_resp[REQ_CPU].ack_r_q;
  assign bus.o_cpu_err   = gen_resp[REQ_CPU].err_q;
  assign bus.o_cpu_rdata = gen_resp[REQ_CPU].rdata_q;
  assign bus.o_dbg_ack   = gen_resp[REQ_DBG].ack_r_q;
  assign bus.o_dbg_err   = gen_resp[REQ_DBG].err_q;
  assign bus.o_dbg_rdata = gen_resp[REQ_DBG].rdata_q;

  // The CPU stalls from request until the cycle its ack appears.
  assign bus.o_cpu_stall = bus.i_cpu_req & ~gen_resp[REQ_CPU].ack_r_q;

  // Contention counter next state: saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((&elig) && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Contention counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_conflict_count = cnt_q;

endmodule
